// File: rtl/dma_burst_sequencer_pkg.sv
// dma_pkg: definitions shared by the DMA sequencer, bus master and slave block.
//   MAX_BURST       default maximum beats per burst
//   BOUNDARY_BYTES  bursts never cross an address boundary of this size
//   dma_seq_state_t burst sequencer FSM states
package dma_pkg;

    localparam int unsigned MAX_BURST      = 16;
    localparam int unsigned BOUNDARY_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        WR_ADDR = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } dma_seq_state_t;

endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: combinational burst size for the next read/write pair.
//   remaining  words left in the transfer
//   src_off    source address offset within its 4 KB page (word aligned)
//   dst_off    destination address offset within its 4 KB page (word aligned)
//   burst      min(remaining, MAX_BURST, words to source boundary,
//              words to destination boundary); >= 1 when remaining != 0
module dma_burst_calc #(
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [11:0]      src_off,
    input  logic [11:0]      dst_off,
    output logic [LEN_W-1:0] burst
);
    import dma_pkg::*;

    // 13 bits so that a page-aligned offset yields the full 4096-byte distance.
    logic [12:0] src_dist;
    logic [12:0] dst_dist;
    logic [12:0] lim;

    always_comb begin
        src_dist = (13'(BOUNDARY_BYTES) - {1'b0, src_off}) >> 2;
        dst_dist = (13'(BOUNDARY_BYTES) - {1'b0, dst_off}) >> 2;
        lim      = 13'(MAX_BURST);
        if (src_dist < lim) lim = src_dist;
        if (dst_dist < lim) lim = dst_dist;
        burst = (remaining < LEN_W'(lim)) ? remaining : LEN_W'(lim);
    end

endmodule

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: DMA control FSM. Latches DMASRC/DMADST/DMALEN on a
// rising edge of DMAEN and issues boundary-safe read/write burst pairs.
//   clk, rst                 clock, asynchronous active-high reset
//   DMAEN/DMASRC/DMADST/DMALEN  programming registers from the slave block
//   rd_req_*                 read burst request (valid/ready, addr, beats-1)
//   rd_beat_valid            one read beat landed in the master buffer
//   wr_req_*                 write burst request (valid/ready, addr, beats-1)
//   wr_resp_valid            write burst completed
//   busy                     transfer in progress (not IDLE/DONE)
//   DMA_interrupt            transfer done, held until DMAEN goes low
module dma_burst_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned MAX_BURST = dma_pkg::MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DMAEN,
    input  logic [ADDR_W-1:0] DMASRC,
    input  logic [ADDR_W-1:0] DMADST,
    input  logic [LEN_W-1:0]  DMALEN,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [3:0]        rd_req_len,
    input  logic              rd_beat_valid,
    output logic              wr_req_valid,
    input  logic              wr_req_ready,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [3:0]        wr_req_len,
    input  logic              wr_resp_valid,
    output logic              busy,
    output logic              DMA_interrupt
);
    import dma_pkg::*;

    dma_seq_state_t    state;
    logic              dmaen_q;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  burst;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  calc_burst;
    logic [LEN_W-1:0]  rem_next;

    dma_burst_calc #(
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .remaining (remaining),
        .src_off   (src[11:0]),
        .dst_off   (dst[11:0]),
        .burst     (calc_burst)
    );

    always_comb begin
        rem_next = remaining - burst;
    end

    // Request outputs are loaded on entry to their address state so that
    // valid, addr and len all come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dmaen_q       <= 1'b0;
            src           <= '0;
            dst           <= '0;
            remaining     <= '0;
            burst         <= '0;
            beat_cnt      <= '0;
            rd_req_valid  <= 1'b0;
            rd_req_addr   <= '0;
            rd_req_len    <= '0;
            wr_req_valid  <= 1'b0;
            wr_req_addr   <= '0;
            wr_req_len    <= '0;
            busy          <= 1'b0;
            DMA_interrupt <= 1'b0;
        end else begin
            dmaen_q <= DMAEN;
            case (state)
                IDLE: begin
                    if (DMAEN && !dmaen_q) begin
                        // Word-align the programmed addresses.
                        src       <= DMASRC & ~ADDR_W'(3);
                        dst       <= DMADST & ~ADDR_W'(3);
                        remaining <= DMALEN;
                        if (DMALEN == '0) begin
                            state         <= DONE;
                            DMA_interrupt <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    burst        <= calc_burst;
                    rd_req_valid <= 1'b1;
                    rd_req_addr  <= src;
                    rd_req_len   <= calc_burst[3:0] - 4'd1;
                    state        <= RD_ADDR;
                end
                RD_ADDR: begin
                    if (rd_req_ready) begin
                        rd_req_valid <= 1'b0;
                        beat_cnt     <= '0;
                        state        <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_beat_valid) begin
                        if (beat_cnt + LEN_W'(1) == burst) begin
                            wr_req_valid <= 1'b1;
                            wr_req_addr  <= dst;
                            wr_req_len   <= burst[3:0] - 4'd1;
                            state        <= WR_ADDR;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                WR_ADDR: begin
                    if (wr_req_ready) begin
                        wr_req_valid <= 1'b0;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (wr_resp_valid) begin
                        src       <= src + ADDR_W'(burst << 2);
                        dst       <= dst + ADDR_W'(burst << 2);
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            DMA_interrupt <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DONE: begin
                    if (!DMAEN) begin
                        state         <= IDLE;
                        DMA_interrupt <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Testbench for dma_burst_sequencer: directed transfers with a scoreboard of
// expected read/write burst requests, a responding bus master model and
// cycle-level checks of start latency, interrupt timing and reset.
module tb_dma_burst_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DMAEN = 1'b0;
    logic [31:0] DMASRC = '0;
    logic [31:0] DMADST = '0;
    logic [31:0] DMALEN = '0;
    logic        rd_req_valid;
    logic        rd_req_ready = 1'b1;
    logic [31:0] rd_req_addr;
    logic [3:0]  rd_req_len;
    logic        rd_beat_valid = 1'b0;
    logic        wr_req_valid;
    logic        wr_req_ready = 1'b1;
    logic [31:0] wr_req_addr;
    logic [3:0]  wr_req_len;
    logic        wr_resp_valid = 1'b0;
    logic        busy;
    logic        DMA_interrupt;

    int n_cmp = 0;
    int n_bad = 0;
    req_t rd_q[$];
    req_t wr_q[$];

    always #5 clk = ~clk;

    dma_burst_sequencer #(
        .ADDR_W    (32),
        .LEN_W     (32),
        .MAX_BURST (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .DMAEN         (DMAEN),
        .DMASRC        (DMASRC),
        .DMADST        (DMADST),
        .DMALEN        (DMALEN),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_len    (rd_req_len),
        .rd_beat_valid (rd_beat_valid),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_len    (wr_req_len),
        .wr_resp_valid (wr_resp_valid),
        .busy          (busy),
        .DMA_interrupt (DMA_interrupt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [31:0] ra, input logic [31:0] wa, input logic [3:0] len);
        req_t r;
        r.addr = ra; r.len = len; rd_q.push_back(r);
        r.addr = wa; wr_q.push_back(r);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drops DMAEN for one edge (clearing any pending DONE), then programs and
    // starts a transfer, checking the two-cycle start latency.
    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] len);
        DMAEN = 1'b0;
        tick();
        check("int_clear_on_en_low", DMA_interrupt, 1'b0);
        DMASRC = s; DMADST = d; DMALEN = len;
        DMAEN = 1'b1;
        tick();
        check("calc_busy", busy, 1'b1);
        check("calc_no_rd_valid", rd_req_valid, 1'b0);
        tick();
        check("rd_valid_latency", rd_req_valid, 1'b1);
    endtask

    // Bus master model: accepts requests, checks them against the scoreboard,
    // returns beats and write responses, checks output timing.
    task automatic run_xfer(input int stall_rd, input int drop_en_at, input bit abort_on_wr,
                            input int budget);
        int   beats_left = 0;
        int   stall = stall_rd;
        int   cyc = 0;
        bit   resp_pend = 0;
        bit   resp_final = 0;
        bit   chk_int = 0;
        bit   chk_wr = 0;
        bit   captured = 0;
        bit   fin = 0;
        logic [31:0] s_addr = '0;
        logic [3:0]  s_len = '0;
        req_t e;
        while (!fin && cyc < budget) begin
            if (chk_int) begin
                check("int_after_resp", DMA_interrupt, resp_final);
                chk_int = 0;
                if (resp_final) fin = 1;
            end
            if (chk_wr) begin
                check("wr_valid_after_last_beat", wr_req_valid, 1'b1);
                chk_wr = 0;
            end
            if (!fin) begin
                if (cyc == drop_en_at) DMAEN = 1'b0;
                rd_beat_valid = (beats_left > 0);
                if (beats_left > 0) begin
                    beats_left--;
                    if (beats_left == 0) chk_wr = 1;
                end
                wr_resp_valid = resp_pend;
                if (resp_pend) begin
                    chk_int = 1;
                    resp_pend = 0;
                end
                if (rd_req_valid && stall > 0) begin
                    rd_req_ready = 1'b0;
                    if (!captured) begin
                        s_addr = rd_req_addr; s_len = rd_req_len; captured = 1;
                    end else begin
                        check("stall_addr_stable", rd_req_addr, s_addr);
                        check("stall_len_stable", rd_req_len, s_len);
                    end
                    stall--;
                end else begin
                    rd_req_ready = 1'b1;
                end
                if (rd_req_valid && rd_req_ready) begin
                    if (rd_q.size() == 0) begin
                        check("rd_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = rd_q.pop_front();
                        check("rd_addr", rd_req_addr, e.addr);
                        check("rd_len", rd_req_len, e.len);
                        beats_left = int'(e.len) + 1;
                    end
                end
                if (wr_req_valid && wr_req_ready) begin
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_addr", wr_req_addr, e.addr);
                        check("wr_len", wr_req_len, e.len);
                        resp_final = (wr_q.size() == 0);
                        if (abort_on_wr) fin = 1;
                        else resp_pend = 1;
                    end
                end
                tick();
                cyc++;
            end
        end
        rd_beat_valid = 1'b0;
        wr_resp_valid = 1'b0;
        rd_req_ready  = 1'b1;
        if (!fin) check("xfer_timeout", 1'b0, 1'b1);
        if (!abort_on_wr) begin
            check("rd_all_issued", rd_q.size(), 0);
            check("wr_all_issued", wr_q.size(), 0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rd_valid", rd_req_valid, 1'b0);
        check("rst_wr_valid", wr_req_valid, 1'b0);
        check("rst_rd_addr", rd_req_addr, 32'h0);
        check("rst_wr_len", wr_req_len, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_int", DMA_interrupt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Aligned transfer: 16, 16, 8
        push_pair(32'h1000, 32'h2000, 4'd15);
        push_pair(32'h1040, 32'h2040, 4'd15);
        push_pair(32'h1080, 32'h2080, 4'd7);
        start(32'h1000, 32'h2000, 32'd40);
        run_xfer(0, -1, 0, 400);
        check("done_busy_low", busy, 1'b0);

        // Source crosses 4 KB boundary: 2 then 8
        push_pair(32'h0FF8, 32'h3000, 4'd1);
        push_pair(32'h1000, 32'h3008, 4'd7);
        start(32'h0FF8, 32'h3000, 32'd10);
        run_xfer(0, -1, 0, 400);

        // Zero length: immediate interrupt, no requests
        DMAEN = 1'b0;
        tick();
        DMALEN = '0;
        DMAEN = 1'b1;
        tick();
        check("len0_int", DMA_interrupt, 1'b1);
        check("len0_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("len0_no_rd", rd_req_valid, 1'b0);
            check("len0_no_wr", wr_req_valid, 1'b0);
            check("len0_int_hold", DMA_interrupt, 1'b1);
        end

        // Read request stalled 5 cycles, DMAEN dropped mid-transfer
        push_pair(32'h4000, 32'h5000, 4'd15);
        push_pair(32'h4040, 32'h5040, 4'd3);
        start(32'h4001, 32'h5003, 32'd20);
        run_xfer(5, 12, 0, 400);
        tick();
        check("int_drop_en_low", DMA_interrupt, 1'b0);

        // Reset during WR_RESP, DMAEN held high across release
        push_pair(32'h0100, 32'h0200, 4'd3);
        start(32'h0100, 32'h0200, 32'd4);
        run_xfer(0, -1, 1, 400);
        rd_q.delete();
        wr_q.delete();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_rd_valid", rd_req_valid, 1'b0);
        check("arst_wr_valid", wr_req_valid, 1'b0);
        check("arst_wr_addr", wr_req_addr, 32'h0);
        check("arst_int", DMA_interrupt, 1'b0);
        DMASRC = 32'h8000; DMADST = 32'h9000; DMALEN = 32'd3;
        push_pair(32'h8000, 32'h9000, 4'd2);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("restart_busy", busy, 1'b1);
        tick();
        check("restart_rd_valid", rd_req_valid, 1'b1);
        run_xfer(0, -1, 0, 400);

        // DMAEN held high in DONE: no restart
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_int", DMA_interrupt, 1'b1);
            check("hold_no_restart", busy, 1'b0);
        end

        // New transfer after DMAEN low; addresses wrap and hit boundaries
        push_pair(32'hFFFF_FFFC, 32'h1FFC, 4'd0);
        push_pair(32'h0000_0000, 32'h2000, 4'd0);
        start(32'hFFFF_FFFC, 32'h1FFC, 32'd2);
        run_xfer(0, -1, 0, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_burst_sequencer.md
# dma_burst_sequencer

Control FSM of the DMA engine: latches the CPU-programmed source, destination and length, then splits the transfer into read/write burst pairs for the DMA bus master. Each read burst fills the master's store-and-forward buffer, and the matching write burst drains it. Bursts never cross a 4 KB boundary on either side. Sits between the DMA slave register block (DMAEN/DMASRC/DMADST/DMALEN) and the DMA master, and raises DMA_interrupt when the transfer completes.

## Interface
- ADDR_W, 32, byte address width
- LEN_W, 32, width of DMALEN (word count)
- MAX_BURST, 16, maximum beats per burst (power of 2, ≤16)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- DMAEN  in  1  enable level; a low→high transition while IDLE starts a transfer
- DMASRC  in  ADDR_W  source byte address; bits [1:0] ignored
- DMADST  in  ADDR_W  destination byte address; bits [1:0] ignored
- DMALEN  in  LEN_W  transfer length in 32-bit words
- rd_req_valid  out  1  read burst request valid
- rd_req_ready  in  1  master accepts read request
- rd_req_addr  out  ADDR_W  read burst start address
- rd_req_len  out  4  read beats minus one
- rd_beat_valid  in  1  one read data beat stored in master buffer
- wr_req_valid  out  1  write burst request valid
- wr_req_ready  in  1  master accepts write request
- wr_req_addr  out  ADDR_W  write burst start address
- wr_req_len  out  4  write beats minus one
- wr_resp_valid  in  1  write burst completed (one pulse per burst)
- busy  out  1  transfer in progress
- DMA_interrupt  out  1  transfer done, level

## Operation
- States: IDLE, CALC, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
- IDLE: on DMAEN high with the previous sample low, latch src, dst and remaining=DMALEN. Go to CALC, or to DONE if DMALEN==0.
- CALC: register burst = min(remaining, MAX_BURST, (4096−src[11:0])>>2, (4096−dst[11:0])>>2). The result is always ≥1. Go to RD_ADDR.
- RD_ADDR: rd_req_valid=1; addr, len stable. On handshake go to RD_DATA with beat counter cleared.
- RD_DATA: count rd_beat_valid. When count reaches burst, go to WR_ADDR. Read-side last signalling is not used.
- WR_ADDR: wr_req_valid=1. On handshake go to WR_RESP.
- WR_RESP: on wr_resp_valid, update src+=burst*4, dst+=burst*4, remaining−=burst. If the new remaining is 0, go to DONE; else go to CALC.
- DONE: DMA_interrupt=1. When DMAEN is low, go to IDLE and clear DMA_interrupt.
- DMAEN is sampled only in IDLE and DONE. Deassertion mid-transfer is ignored, and the transfer runs to completion.
- Addresses wrap modulo 2^ADDR_W. Burst arithmetic is done in LEN_W bits with no saturation.
- Inputs arriving in the wrong state are ignored: rd_beat_valid outside RD_DATA, wr_resp_valid outside WR_RESP.

## Timing
- Reset: state IDLE. All outputs 0: rd/wr_req_valid, addr, len, busy, DMA_interrupt. The DMAEN edge register is 0.
- rst asserted mid-transfer aborts immediately with no interrupt. A start after reset needs a fresh DMAEN rising edge; DMAEN already high at reset release counts as a rising edge.
- Start latency: DMAEN sampled high at edge N → CALC in N+1 → rd_req_valid high from N+2.
- busy is high in every state except IDLE and DONE.
- valid/ready: once valid is asserted, it and addr/len hold until the cycle in which ready is high. Valid drops the next cycle. ready is allowed to be high before valid.
- Final rd_beat_valid at edge M → wr_req_valid high from M+1.
- wr_resp_valid at edge K → next rd_req_valid at K+2 (via CALC), or DMA_interrupt high at K+1.
- All outputs are registered.

## Structure
- Shared package dma_pkg: the state enum dma_seq_state_t, MAX_BURST, and BOUNDARY_BYTES=4096. The master and slave reuse these.
- Sub-module dma_burst_calc: combinational min of remaining, MAX_BURST and the two boundary distances. Instantiated once and feeds the CALC register.

## Test plan
- SRC=0x1000, DST=0x2000, LEN=40, ready always 1 → bursts of 16, 16, 8; rd/wr_req_len = 15, 15, 7; addrs advance by 0x40; interrupt after the 3rd wr_resp.
- SRC=0x0FF8, DST=0x3000, LEN=10 → bursts 2 (stops at the 4 KB boundary) then 8; rd_req_addr 0x0FF8 then 0x1000.
- LEN=0 with DMAEN rising → DMA_interrupt high 1 cycle later, no requests issued, busy stays 0.
- rd_req_ready held low 5 cycles → rd_req_valid/addr/len stable for all 5, one handshake only; DMAEN dropped mid-burst → transfer still completes.
- rst pulsed during WR_RESP → all outputs 0 asynchronously; DMAEN held high at release → new transfer starts from the re-latched registers.
- DMAEN held high through DONE → interrupt stays 1 with no restart; DMAEN low → interrupt 0 next cycle; DMAEN high again → new transfer.
